// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single Decode register-file write port.
// The grant (reqReady) is combinational. The winning payload is registered
// and presented to Decode for exactly one cycle, so it is stable before the
// falling-edge write.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_SIZE   = 6,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_REQ       = 3
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                writeStall,
    input  logic [NUM_REQ-1:0]                                  reqValid,
    input  logic [NUM_REQ-1:0]                                  reqIsVector,
    input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]               reqAddress,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]                  reqScalarData,
    input  logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] reqVectorData,
    output logic [NUM_REQ-1:0]                                  reqReady,
    output logic                                                writeEnableScalar,
    output logic                                                writeEnableVector,
    output logic [ADDRESS_WIDTH-1:0]                            writeAddress,
    output logic [DATA_WIDTH-1:0]                               writeScalarData,
    output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              writeVectorData,
    output logic [7:0]                                          grantCount
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Advance the round-robin pointer past the winner, wrapping at NUM_REQ.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(NUM_REQ - 1)) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    logic [PTR_W-1:0]                   rr_pointer_r;
    logic [7:0]                         grant_count_r;
    logic                               we_scalar_r;
    logic                               we_vector_r;
    logic [ADDRESS_WIDTH-1:0]           addr_r;
    logic [DATA_WIDTH-1:0]              sdata_r;
    logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] vdata_r;

    logic                               found_s;
    logic [PTR_W-1:0]                   win_idx_s;
    logic                               grant_ok_s;

    // Find the first valid requester at or after the round-robin pointer.
    always_comb begin
        int               cand_v;
        logic [PTR_W-1:0] cand_idx_v;
        found_s    = 1'b0;
        win_idx_s  = '0;
        cand_v     = 0;
        cand_idx_v = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_v = int'(rr_pointer_r) + k;
            if (cand_v >= NUM_REQ) begin
                cand_v = cand_v - NUM_REQ;
            end else begin
                cand_v = cand_v;
            end
            cand_idx_v = PTR_W'(cand_v);
            if (!found_s && reqValid[cand_idx_v]) begin
                found_s   = 1'b1;
                win_idx_s = cand_idx_v;
            end else begin
                found_s   = found_s;
                win_idx_s = win_idx_s;
            end
        end
    end

    // Grant is suppressed by stall and while reset is asserted.
    assign grant_ok_s = found_s & ~writeStall & reset;

    // One-hot ready toward the winning requester.
    always_comb begin
        reqReady = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_ok_s && (win_idx_s == PTR_W'(i))) begin
                reqReady[i] = 1'b1;
            end else begin
                reqReady[i] = 1'b0;
            end
        end
    end

    // Capture the winning write and pulse the matching enable for one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_pointer_r  <= '0;
            grant_count_r <= 8'd0;
            we_scalar_r   <= 1'b0;
            we_vector_r   <= 1'b0;
            addr_r        <= '0;
            sdata_r       <= '0;
            vdata_r       <= '0;
        end else if (grant_ok_s) begin
            we_scalar_r   <= ~reqIsVector[win_idx_s];
            we_vector_r   <= reqIsVector[win_idx_s];
            addr_r        <= reqAddress[win_idx_s];
            if (reqIsVector[win_idx_s]) begin
                vdata_r <= reqVectorData[win_idx_s];
            end else begin
                sdata_r <= reqScalarData[win_idx_s];
            end
            rr_pointer_r  <= next_ptr(win_idx_s);
            grant_count_r <= grant_count_r + 8'd1;
        end else begin
            we_scalar_r   <= 1'b0;
            we_vector_r   <= 1'b0;
        end
    end

    assign writeEnableScalar = we_scalar_r;
    assign writeEnableVector = we_vector_r;
    assign writeAddress      = addr_r;
    assign writeScalarData   = sdata_r;
    assign writeVectorData   = vdata_r;
    assign grantCount        = grant_count_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge, where reqReady reflects the current inputs and the write
// outputs reflect the handshake of the previous rising edge.
module tb_regfile_write_arbiter;

    localparam logic [47:0] VV = 48'h010203040506;
    localparam logic [47:0] VJUNK = 48'hFFFFFFFFFFFF;

    logic                 clock;
    logic                 reset;
    logic                 writeStall;
    logic [2:0]           reqValid;
    logic [2:0]           reqIsVector;
    logic [2:0][3:0]      reqAddress;
    logic [2:0][7:0]      reqScalarData;
    logic [2:0][5:0][7:0] reqVectorData;
    logic [2:0]           reqReady;
    logic                 writeEnableScalar;
    logic                 writeEnableVector;
    logic [3:0]           writeAddress;
    logic [7:0]           writeScalarData;
    logic [5:0][7:0]      writeVectorData;
    logic [7:0]           grantCount;

    int checks;
    int errors;

    regfile_write_arbiter #(
        .DATA_WIDTH(8), .VECTOR_SIZE(6), .ADDRESS_WIDTH(4), .NUM_REQ(3)
    ) dut (
        .clock(clock), .reset(reset), .writeStall(writeStall),
        .reqValid(reqValid), .reqIsVector(reqIsVector), .reqAddress(reqAddress),
        .reqScalarData(reqScalarData), .reqVectorData(reqVectorData),
        .reqReady(reqReady), .writeEnableScalar(writeEnableScalar),
        .writeEnableVector(writeEnableVector), .writeAddress(writeAddress),
        .writeScalarData(writeScalarData), .writeVectorData(writeVectorData),
        .grantCount(grantCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  valid;
        logic        stall;
        logic [2:0]  exp_ready;
        logic        exp_ws;
        logic        exp_wv;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_sd;
        logic [47:0] exp_vd;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reqValid   = 3'b000;
        writeStall = 1'b0;
        reset      = 1'b0;
        repeat (2) @(negedge clock);
        reset      = 1'b1;
    endtask

    initial begin
        int   since;
        int   max_gap;
        int   g0;
        int   g1;
        int   g2;
        logic [2:0] exp_ready;

        checks = 0;
        errors = 0;

        reqIsVector   = 3'b100;
        reqAddress    = {4'd9, 4'd7, 4'd5};
        reqScalarData = {8'hEE, 8'h5C, 8'hA3};
        reqVectorData = {VV, VJUNK, VJUNK};
        writeStall    = 1'b0;
        reqValid      = 3'b111;
        reset         = 1'b0;

        // Reset state, with requests pending to show reqReady is gated.
        @(negedge clock);
        check("reset_ready", 64'(reqReady), 64'd0);
        check("reset_we_s", 64'(writeEnableScalar), 64'd0);
        check("reset_we_v", 64'(writeEnableVector), 64'd0);
        check("reset_addr", 64'(writeAddress), 64'd0);
        check("reset_sdata", 64'(writeScalarData), 64'd0);
        check("reset_vdata", 64'(writeVectorData), 64'd0);
        check("reset_count", 64'(grantCount), 64'd0);
        do_reset();

        // valid, stall, ready, we_s, we_v, addr, sdata, vdata, count
        vecs[0]  = '{3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 4'd0, 8'h00, 48'h0, 8'd0};
        vecs[1]  = '{3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 4'd5, 8'hA3, 48'h0, 8'd1};
        vecs[2]  = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd5, 8'hA3, 48'h0, 8'd1};
        vecs[3]  = '{3'b111, 1'b0, 3'b010, 1'b0, 1'b0, 4'd5, 8'hA3, 48'h0, 8'd1};
        vecs[4]  = '{3'b111, 1'b0, 3'b100, 1'b1, 1'b0, 4'd7, 8'h5C, 48'h0, 8'd2};
        vecs[5]  = '{3'b111, 1'b0, 3'b001, 1'b0, 1'b1, 4'd9, 8'h5C, VV,    8'd3};
        vecs[6]  = '{3'b111, 1'b1, 3'b000, 1'b1, 1'b0, 4'd5, 8'hA3, VV,    8'd4};
        vecs[7]  = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 4'd5, 8'hA3, VV,    8'd4};
        vecs[8]  = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 4'd5, 8'hA3, VV,    8'd4};
        vecs[9]  = '{3'b111, 1'b0, 3'b010, 1'b0, 1'b0, 4'd5, 8'hA3, VV,    8'd4};
        vecs[10] = '{3'b110, 1'b0, 3'b100, 1'b1, 1'b0, 4'd7, 8'h5C, VV,    8'd5};
        vecs[11] = '{3'b011, 1'b0, 3'b001, 1'b0, 1'b1, 4'd9, 8'h5C, VV,    8'd6};
        vecs[12] = '{3'b100, 1'b0, 3'b100, 1'b1, 1'b0, 4'd5, 8'hA3, VV,    8'd7};
        vecs[13] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 4'd9, 8'hA3, VV,    8'd8};
        vecs[14] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd9, 8'hA3, VV,    8'd8};

        for (int r = 0; r < 15; r++) begin
            @(posedge clock);
            #1;
            reqValid   = vecs[r].valid;
            writeStall = vecs[r].stall;
            @(negedge clock);
            check($sformatf("row%0d_ready", r), 64'(reqReady), 64'(vecs[r].exp_ready));
            check($sformatf("row%0d_we_s", r), 64'(writeEnableScalar), 64'(vecs[r].exp_ws));
            check($sformatf("row%0d_we_v", r), 64'(writeEnableVector), 64'(vecs[r].exp_wv));
            check($sformatf("row%0d_addr", r), 64'(writeAddress), 64'(vecs[r].exp_addr));
            check($sformatf("row%0d_sdata", r), 64'(writeScalarData), 64'(vecs[r].exp_sd));
            check($sformatf("row%0d_vdata", r), 64'(writeVectorData), 64'(vecs[r].exp_vd));
            check($sformatf("row%0d_count", r), 64'(grantCount), 64'(vecs[r].exp_cnt));
        end

        // Reset asserted the cycle after a handshake drops the pending write.
        @(posedge clock);
        #1;
        reqValid = 3'b010;
        @(posedge clock);
        #1;
        reqValid = 3'b000;
        @(negedge clock);
        check("midrst_pre_we_s", 64'(writeEnableScalar), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_we_s", 64'(writeEnableScalar), 64'd0);
        check("midrst_we_v", 64'(writeEnableVector), 64'd0);
        check("midrst_count", 64'(grantCount), 64'd0);
        reqValid = 3'b111;
        #1;
        check("midrst_ready_gated", 64'(reqReady), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("postrst_count", 64'(grantCount), 64'd0);

        // All three valid for six cycles from reset: order 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge clock);
            end
            exp_ready = 3'b001 << (k % 3);
            check($sformatf("rr_order%0d", k), 64'(reqReady), 64'(exp_ready));
        end
        @(posedge clock);
        #1;
        reqValid = 3'b000;
        @(negedge clock);
        check("rr_count6", 64'(grantCount), 64'd6);
        check("rr_last_vec", 64'(writeEnableVector), 64'd1);
        check("rr_last_addr", 64'(writeAddress), 64'd9);

        // 256 back-to-back grants: counter wraps, requester 1 never starved.
        do_reset();
        reqValid = 3'b111;
        #1;
        since   = 0;
        max_gap = 0;
        g0 = 0;
        g1 = 0;
        g2 = 0;
        for (int c = 0; c < 256; c++) begin
            if (c == 255) begin
                check("wrap_count255", 64'(grantCount), 64'd255);
            end
            if (reqReady[0]) g0++;
            if (reqReady[2]) g2++;
            if (reqReady[1]) begin
                g1++;
                since = 0;
            end else begin
                since++;
                if (since > max_gap) max_gap = since;
            end
            @(negedge clock);
            #1;
        end
        check("wrap_count0", 64'(grantCount), 64'd0);
        check("starve_req1", 64'(max_gap), 64'd2);
        check("fair_g0", 64'(g0), 64'd86);
        check("fair_g1", 64'(g1), 64'd85);
        check("fair_g2", 64'(g2), 64'd85);
        reqValid = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
